// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier datapath:
// controller states, shift codes and datapath widths.
package mult_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned PP_W     = 8;
  localparam int unsigned PROD_W   = 16;

  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH4 = 2'b01;
  localparam logic [1:0] SH8 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/pp_align.sv
// Partial-product alignment: places the 8-bit product of the shared 4x4
// multiplier at nibble offset 0, 4 or 8 of the 16-bit result, mirroring the
// nibble-selection muxes on the operand side. Code 2'b11 is flagged illegal.
module pp_align
  import mult_pkg::*;
(
  input  logic [7:0]  pp_in,
  input  logic [1:0]  shift_sel,
  output logic [15:0] aligned,
  output logic        legal
);

  // Shift mux; illegal code yields zero and deasserts legal
  always_comb begin
    aligned = '0;
    legal   = 1'b1;
    case (shift_sel)
      SH0:     aligned = {{(PROD_W-PP_W){1'b0}}, pp_in};
      SH4:     aligned = {{(PROD_W-PP_W-NIBBLE_W){1'b0}}, pp_in, {NIBBLE_W{1'b0}}};
      SH8:     aligned = {pp_in, {(PROD_W-PP_W){1'b0}}};
      default: begin
        aligned = '0;
        legal   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pp_accumulator.sv
// Partial-product accumulator: sums PP_COUNT aligned partial products into a
// 16-bit product register, then holds the result with done set until the
// next start or reset.
// Optional build macro PP_ACCUM_OVF_CHECK_EN adds a sticky carry-out flag
// (ovf); without it ovf is tied low.
module pp_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned PP_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pp_in,
  input  logic        pp_valid,
  input  logic [1:0]  shift_sel,
  output logic [15:0] product,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          cnt_inc;
  logic [PROD_W-1:0]   product_q, product_d;
  logic [PROD_W-1:0]   aligned_w;
  logic                legal_w;
  logic [PROD_W-1:0]   acc_sum;
  logic                accept;

  pp_align u_pp_align (
    .pp_in     (pp_in),
    .shift_sel (shift_sel),
    .aligned   (aligned_w),
    .legal     (legal_w)
  );

  assign accept  = (state_q == ACCUM) && !start && pp_valid && legal_w;
  assign cnt_inc = cnt_q + 3'd1;

`ifdef PP_ACCUM_OVF_CHECK_EN
  logic [PROD_W:0] sum_w;
  logic            ovf_q, ovf_d;

  // 17-bit sum so the carry out of bit 15 is visible
  always_comb begin
    sum_w   = {1'b0, product_q} + {1'b0, aligned_w};
    acc_sum = sum_w[PROD_W-1:0];
  end

  // Sticky carry flag, cleared by start
  always_comb begin
    ovf_d = ovf_q;
    if (start)
      ovf_d = 1'b0;
    else if (accept && sum_w[PROD_W])
      ovf_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (reset)
      ovf_q <= 1'b0;
    else
      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  // Plain 16-bit sum; bits above 15 are dropped
  always_comb begin
    acc_sum = product_q + aligned_w;
  end

  assign ovf = 1'b0;
`endif

  // Next state, count and accumulator value
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (start) begin
      state_d   = ACCUM;
      cnt_d     = '0;
      product_d = '0;
    end else if (accept) begin
      product_d = acc_sum;
      cnt_d     = cnt_inc;
      if ({29'd0, cnt_inc} == PP_COUNT)
        state_d = DONE;
    end
  end

  // State, count and accumulator registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == ACCUM);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench for pp_accumulator: directed test-plan scenarios
// followed by randomized traffic, all compared against an arithmetic model.
module tb_pp_accumulator;

  logic        clk = 1'b0;
  logic        reset, start, pp_valid;
  logic [7:0]  pp_in;
  logic [1:0]  shift_sel;
  logic [15:0] product;
  logic        busy, done, ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: accumulated value as an integer, phase flags, count
  int m_prod = 0;
  int m_cnt  = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit m_ovf  = 0;

`ifdef PP_ACCUM_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  pp_accumulator #(.PP_COUNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pp_in     (pp_in),
    .pp_valid  (pp_valid),
    .shift_sel (shift_sel),
    .product   (product),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit v,
                              input int p, input int sel);
    int total;
    if (r) begin
      m_prod = 0; m_cnt = 0; m_busy = 0; m_done = 0; m_ovf = 0;
    end else if (s) begin
      m_prod = 0; m_cnt = 0; m_busy = 1; m_done = 0; m_ovf = 0;
    end else if (m_busy && v && sel != 3) begin
      total = m_prod + p * (1 << (4 * sel));
      if (OVF_EN && total > 65535) m_ovf = 1;
      m_prod = total % 65536;
      m_cnt++;
      if (m_cnt == 4) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 ns later
  task automatic step(input bit r, input bit s, input bit v,
                      input logic [7:0] p, input logic [1:0] sel);
    reset = r; start = s; pp_valid = v; pp_in = p; shift_sel = sel;
    @(posedge clk);
    model_update(r, s, v, int'(p), int'(sel));
    #1;
    check("product", product, m_prod[15:0]);
    check("busy",    {15'd0, busy}, {15'd0, m_busy});
    check("done",    {15'd0, done}, {15'd0, m_done});
    check("ovf",     {15'd0, ovf},  {15'd0, m_ovf});
  endtask

  task automatic pp(input logic [7:0] p, input logic [1:0] sel);
    step(0, 0, 1, p, sel);
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 2'b00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pp_valid = 1'b0; pp_in = '0; shift_sel = '0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 8'h00, 2'b00);
    check("rst_product", product, 16'h0000);
    step(0, 0, 1, 8'h55, 2'b00);   // pp_valid ignored in IDLE
    check("idle_ignore", product, 16'h0000);

    // Full-scale product 0xFF x 0xFF
    step(0, 1, 1, 8'hAA, 2'b00);   // pp_valid alongside start ignored
    check("start_clear", product, 16'h0000);
    pp(8'hE1, 2'b00);
    pp(8'hE1, 2'b01);
    pp(8'hE1, 2'b01);
    check("done_not_yet", {15'd0, done}, 16'h0000);
    pp(8'hE1, 2'b10);
    check("full_product", product, 16'hFE01);
    check("full_done", {15'd0, done}, 16'h0001);
    check("full_ovf", {15'd0, ovf}, 16'h0000);
    pp(8'h77, 2'b00);              // ignored in DONE
    check("done_hold", product, 16'hFE01);

    // Gaps and ordering: 0x12 x 0x34
    step(0, 1, 0, 8'h00, 2'b00);
    check("done_falls", {15'd0, done}, 16'h0000);
    pp(8'h03, 2'b10);
    idle();
    pp(8'h06, 2'b01);
    pp(8'h08, 2'b00);
    idle();
    check("gap_not_done", {15'd0, done}, 16'h0000);
    pp(8'h04, 2'b01);
    check("gap_product", product, 16'h03A8);
    check("gap_done", {15'd0, done}, 16'h0001);

    // Illegal shift code mid-sequence
    step(0, 1, 0, 8'h00, 2'b00);
    pp(8'h10, 2'b00);
    pp(8'hFF, 2'b11);
    check("illegal_hold", product, 16'h0010);
    pp(8'h10, 2'b01);
    pp(8'h10, 2'b10);
    check("illegal_count", {15'd0, done}, 16'h0000);
    pp(8'h01, 2'b00);
    check("illegal_final", product, 16'h1111);

    // Reset mid-operation
    step(0, 1, 0, 8'h00, 2'b00);
    pp(8'h20, 2'b00);
    pp(8'h20, 2'b01);
    step(1, 0, 1, 8'h40, 2'b10);
    check("midrst_product", product, 16'h0000);
    pp(8'h40, 2'b10);
    check("midrst_ignore", product, 16'h0000);

    // Restart during ACCUM
    step(0, 1, 0, 8'h00, 2'b00);
    pp(8'h11, 2'b00);
    pp(8'h22, 2'b01);
    pp(8'h33, 2'b10);
    step(0, 1, 0, 8'h00, 2'b00);
    check("restart_clear", product, 16'h0000);
    pp(8'h01, 2'b00);
    pp(8'h00, 2'b01);
    pp(8'h00, 2'b01);
    pp(8'h00, 2'b10);
    check("restart_product", product, 16'h0001);

    // Overflow: four 0xFF<<8
    step(0, 1, 0, 8'h00, 2'b00);
    pp(8'hFF, 2'b10);
    check("ovf_first", {15'd0, ovf}, 16'h0000);
    pp(8'hFF, 2'b10);
    check("ovf_second", {15'd0, ovf}, {15'd0, OVF_EN});
    pp(8'hFF, 2'b10);
    pp(8'hFF, 2'b10);
    check("ovf_product", product, 16'hFC00);
    check("ovf_final", {15'd0, ovf}, {15'd0, OVF_EN});

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 7), 8'($urandom), 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
